// File: rtl/fp_mul_round_pipeline.sv
// fp_mul_round_pipeline: FP32 significand multiply, normalize, round and pack with IEEE flags, 3-stage pipeline.
module fp_mul_round_pipeline #(
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        special_case,
  input  logic [31:0] special_result,
  input  logic        input_is_invalid,
  input  logic        input_is_flushed,
  input  logic [2:0]  rounding_mode,
  output logic [31:0] out,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact,
  output logic        invalid_operation,
  output logic        valid_out
);
  if (LATENCY != 3) begin : g_bad_latency
    $error("fp_mul_round_pipeline supports only LATENCY == 3");
  end
  // Sideband = {special_case, special_result, input_is_invalid, input_is_flushed, rounding_mode}
  logic [37:0] side_d, side_a_q, side_b_q;
  logic        v_a_q, v_b_q, v_c_q;
  logic [47:0] p_d, p_a_q;
  logic [9:0]  e_a_d, e_a_q, e_b_d, e_b_q;
  logic        sign_a_q, sign_b_q;
  logic [22:0] m_b_d, m_b_q;
  logic        g_b_d, g_b_q, s_b_d, s_b_q;
  assign side_d = {special_case, special_result, input_is_invalid, input_is_flushed, rounding_mode};
  assign p_d    = 48'({1'b1, in1[22:0]}) * 48'({1'b1, in2[22:0]});
  assign e_a_d  = {2'b0, in1[30:23]} + {2'b0, in2[30:23]} - 10'd127;
  always_comb begin
    m_b_d = p_a_q[47] ? p_a_q[46:24] : p_a_q[45:23];
    g_b_d = p_a_q[47] ? p_a_q[23] : p_a_q[22];
    s_b_d = p_a_q[47] ? |p_a_q[22:0] : |p_a_q[21:0];
    e_b_d = e_a_q + {9'd0, p_a_q[47]};
  end
  logic        sc, inv, fl;
  logic [31:0] sr;
  logic [2:0]  rm;
  logic        inc, carry, ovf, unf, to_inf;
  logic [22:0] m_r;
  logic [9:0]  e_r;
  logic [31:0] out_d, out_q;
  logic        ovf_d, unf_d, inx_d, inv_d;
  logic        ovf_q, unf_q, inx_q, inv_q;
  assign {sc, sr, inv, fl, rm} = side_b_q;
  always_comb begin
    inc = rm == 3'd1 ? 1'b0 :
          rm == 3'd2 ? sign_b_q & (g_b_q | s_b_q) :
          rm == 3'd3 ? ~sign_b_q & (g_b_q | s_b_q) :
          rm == 3'd4 ? g_b_q : g_b_q & (s_b_q | m_b_q[0]);
    {carry, m_r} = {1'b0, m_b_q} + {23'd0, inc};
    e_r = e_b_q + {9'd0, carry};
    ovf = $signed(e_r) >= 10'sd255;
    unf = $signed(e_r) <= 10'sd0;
    to_inf = rm == 3'd1 ? 1'b0 : rm == 3'd2 ? sign_b_q : rm == 3'd3 ? ~sign_b_q : 1'b1;
    out_d = inv ? 32'h7FC0_0000 :
            sc  ? sr :
            ovf ? {sign_b_q, to_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF} :
            unf ? {sign_b_q, 31'd0} : {sign_b_q, e_r[7:0], m_r};
    ovf_d = v_b_q & ~inv & ~sc & ovf;
    unf_d = v_b_q & ~inv & ~sc & ~ovf & unf;
    inx_d = v_b_q & ~inv & (sc ? fl & (sr[30:0] == 31'd0) : ovf | unf | g_b_q | s_b_q);
    inv_d = v_b_q & inv;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      {v_a_q, v_b_q, v_c_q} <= '0;
      {side_a_q, side_b_q} <= '0;
      {p_a_q, e_a_q, sign_a_q} <= '0;
      {m_b_q, g_b_q, s_b_q, e_b_q, sign_b_q} <= '0;
      {out_q, ovf_q, unf_q, inx_q, inv_q} <= '0;
    end else begin
      {v_a_q, v_b_q, v_c_q} <= {valid_in, v_a_q, v_b_q};
      {side_a_q, side_b_q} <= {side_d, side_a_q};
      {p_a_q, e_a_q, sign_a_q} <= {p_d, e_a_d, in1[31] ^ in2[31]};
      {m_b_q, g_b_q, s_b_q, e_b_q, sign_b_q} <= {m_b_d, g_b_d, s_b_d, e_b_d, sign_a_q};
      {out_q, ovf_q, unf_q, inx_q, inv_q} <= {out_d, ovf_d, unf_d, inx_d, inv_d};
    end
  end
  assign out               = out_q;
  assign overflow          = ovf_q;
  assign underflow         = unf_q;
  assign inexact           = inx_q;
  assign invalid_operation = inv_q;
  assign valid_out         = v_c_q;
endmodule

// File: tb/tb_fp_mul_round_pipeline.sv
// tb_fp_mul_round_pipeline: directed vectors with hand-computed results for the FP32 multiply round pipeline.
module tb_fp_mul_round_pipeline;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] in1, in2, special_result;
  logic        special_case, input_is_invalid, input_is_flushed;
  logic [2:0]  rounding_mode;
  logic [31:0] out;
  logic        overflow, underflow, inexact, invalid_operation, valid_out;
  int          n_chk = 0;
  int          n_pass = 0;
  always #5 clk = ~clk;
  fp_mul_round_pipeline #(.LATENCY(3)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .in1(in1), .in2(in2),
    .special_case(special_case), .special_result(special_result),
    .input_is_invalid(input_is_invalid), .input_is_flushed(input_is_flushed),
    .rounding_mode(rounding_mode), .out(out), .overflow(overflow),
    .underflow(underflow), .inexact(inexact), .invalid_operation(invalid_operation),
    .valid_out(valid_out)
  );
  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  rm;
    logic        sc;
    logic [31:0] sr;
    logic        inv, fl;
    logic [31:0] eo;
    logic [3:0]  ef;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask
  function automatic logic [3:0] flags();
    return {overflow, underflow, inexact, invalid_operation};
  endfunction
  task automatic drive(input vec_t v);
    valid_in = 1'b1;
    in1 = v.a;
    in2 = v.b;
    rounding_mode = v.rm;
    special_case = v.sc;
    special_result = v.sr;
    input_is_invalid = v.inv;
    input_is_flushed = v.fl;
  endtask
  task automatic idle();
    valid_in = 1'b0;
    in1 = '0;
    in2 = '0;
    rounding_mode = '0;
    special_case = 1'b0;
    special_result = '0;
    input_is_invalid = 1'b0;
    input_is_flushed = 1'b0;
  endtask
  task automatic run_one(input int idx, input vec_t v);
    int lat;
    @(negedge clk);
    drive(v);
    @(negedge clk);
    idle();
    lat = 1;
    while (!valid_out && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'd3);
    chk($sformatf("v%0d out", idx), out, v.eo);
    chk($sformatf("v%0d flags", idx), 32'(flags()), 32'(v.ef));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    // flags field = {overflow, underflow, inexact, invalid}
    vecs.push_back('{32'h3FC00000, 32'h40000000, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h40400000, 4'b0000});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h3F800002, 4'b0010});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 3'd3, 1'b0, 32'h0, 1'b0, 1'b0, 32'h3F800003, 4'b0010});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 3'd1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h3F800002, 4'b0010});
    vecs.push_back('{32'h3F800001, 32'h3F800001, 3'd4, 1'b0, 32'h0, 1'b0, 1'b0, 32'h3F800002, 4'b0010});
    vecs.push_back('{32'h7F000000, 32'h40000000, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h7F800000, 4'b1010});
    vecs.push_back('{32'h7F000000, 32'h40000000, 3'd1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h7F7FFFFF, 4'b1010});
    vecs.push_back('{32'hFF000000, 32'h40000000, 3'd3, 1'b0, 32'h0, 1'b0, 1'b0, 32'hFF7FFFFF, 4'b1010});
    vecs.push_back('{32'hFF000000, 32'h40000000, 3'd2, 1'b0, 32'h0, 1'b0, 1'b0, 32'hFF800000, 4'b1010});
    vecs.push_back('{32'h00800000, 32'h3F000000, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h00000000, 4'b0110});
    vecs.push_back('{32'h80800000, 32'h00800000, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h80000000, 4'b0110});
    vecs.push_back('{32'h3FFFFFFE, 32'h3F800001, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h40000000, 4'b0010});
    vecs.push_back('{32'h3FFFFFFE, 32'h3F800001, 3'd1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h3FFFFFFF, 4'b0010});
    vecs.push_back('{32'h3FFFFFFE, 32'h3F800001, 3'd7, 1'b0, 32'h0, 1'b0, 1'b0, 32'h40000000, 4'b0010});
    vecs.push_back('{32'h7F7FFFFE, 32'h3F800001, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h7F800000, 4'b1010});
    vecs.push_back('{32'h7E800000, 32'h40000000, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h7F000000, 4'b0000});
    vecs.push_back('{32'h00800000, 32'h3F800000, 3'd0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h00800000, 4'b0000});
    vecs.push_back('{32'h7F800000, 32'h00000000, 3'd0, 1'b1, 32'h12345678, 1'b1, 1'b0, 32'h7FC00000, 4'b0001});
    vecs.push_back('{32'h80000000, 32'h3F800000, 3'd0, 1'b1, 32'h80000000, 1'b0, 1'b1, 32'h80000000, 4'b0010});
    vecs.push_back('{32'h7F800000, 32'h3F800000, 3'd0, 1'b1, 32'h7F800000, 1'b0, 1'b1, 32'h7F800000, 4'b0000});
    rst = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    chk("reset out", out, 32'h0);
    chk("reset flags", 32'(flags()), 32'h0);
    chk("reset valid", 32'(valid_out), 32'h0);
    rst = 1'b1;
    foreach (vecs[i]) run_one(i, vecs[i]);
    // Back-to-back: three ops on consecutive cycles, then a bubble.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 3 && i < 6) begin
        chk($sformatf("b2b%0d valid", i - 3), 32'(valid_out), 32'h1);
        chk($sformatf("b2b%0d out", i - 3), out, vecs[i - 3].eo);
        chk($sformatf("b2b%0d flags", i - 3), 32'(flags()), 32'(vecs[i - 3].ef));
      end
      if (i == 6) chk("b2b bubble valid", 32'(valid_out), 32'h0);
      if (i < 3) drive(vecs[i]);
      else idle();
    end
    repeat (3) @(negedge clk);
    // Four back-to-back ops, reset one cycle after the last input.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(vecs[i + 1]);
    end
    @(negedge clk);
    idle();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("in-reset%0d valid", i), 32'(valid_out), 32'h0);
      chk($sformatf("in-reset%0d out", i), out, 32'h0);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post-reset%0d valid", i), 32'(valid_out), 32'h0);
      chk($sformatf("post-reset%0d out", i), out, 32'h0);
      chk($sformatf("post-reset%0d flags", i), 32'(flags()), 32'h0);
    end
    run_one(99, vecs[0]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fp_mul_round_pipeline.md
Name: fp_mul_round_pipeline

Overview:
- Downstream continuation of the FP32 multiply pipeline.
- Consumes the per-operation bundle produced by the special-case/denorm stage: raw operands, special-case result and flags, rounding mode, valid.
- Performs the 24x24 significand multiply, exponent sum, normalization, IEEE-754 rounding and packing, then raises overflow/underflow/inexact/invalid.
- Fully pipelined: one operation per cycle, fixed 3-cycle latency, flush-to-zero for tiny results.

Parameters:
LATENCY, 3, pipeline depth from valid_in to valid_out (fixed; any other value is illegal)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-low
valid_in  input  1  bundle on the inputs is a live operation
in1  input  32  operand A, raw FP32
in2  input  32  operand B, raw FP32
special_case  input  1  special_result overrides arithmetic
special_result  input  32  precomputed result (NaN, inf, signed zero)
input_is_invalid  input  1  sNaN operand or inf*0
input_is_flushed  input  1  a denormal operand was flushed to zero
rounding_mode  input  3  0=RNE 1=RTZ 2=RDN 3=RUP 4=RMM; 5-7 treated as RNE
out  output  32  FP32 product
overflow  output  1  IEEE overflow flag
underflow  output  1  IEEE underflow flag (FTZ)
inexact  output  1  IEEE inexact flag
invalid_operation  output  1  IEEE invalid flag
valid_out  output  1  outputs hold a completed operation

Behaviour:
- Reset (rst==0 at clk edge):
  - All pipeline registers clear, including stage valids.
  - out=0, all flags=0, valid_out=0.
  - Reset mid-operation discards all in-flight operations; nothing emerges afterwards.
- Data registers load every cycle regardless of valid_in. Outputs are meaningful only when valid_out=1. Flags are qualified by valid_out.
- Stage A (cycle 1):
  - Significands ma={1,in1[22:0]}, mb={1,in2[22:0]}.
  - Product p = ma*mb, 48b.
  - Exponent e = in1[30:23]+in2[30:23]-127, 10-bit signed.
  - sign = in1[31]^in2[31].
  - Sideband bundle carried forward.
- Stage B (cycle 2), normalization:
  - If p[47]=1: m=p[46:24], g=p[23], s=|p[22:0], e=e+1.
  - Else: m=p[45:23], g=p[22], s=|p[21:0].
- Stage C (cycle 3), rounding:
  - Increment decision:
    - RNE: inc = g&(s|m[0])
    - RTZ: inc = 0
    - RDN: inc = sign&(g|s)
    - RUP: inc = ~sign&(g|s)
    - RMM: inc = g
  - m+inc carry out sets m=0 and e=e+1.
  - Tininess is evaluated after rounding.
- Result selection, in priority order:
  1. input_is_invalid: out=0x7FC00000, invalid_operation=1, other flags 0.
  2. special_case: out=special_result. inexact=input_is_flushed && special_result is a signed zero; other flags 0.
  3. e>=255: overflow=1, inexact=1. out=±inf for RNE/RMM, RDN with sign=1, RUP with sign=0; otherwise ±0x7F7FFFFF.
  4. e<=0: out={sign,31'd0}, underflow=1, inexact=1.
  5. Otherwise: out={sign,e[7:0],m}, inexact=g|s.
- Timing and throughput:
  - valid_out asserts exactly 3 cycles after valid_in is sampled.
  - Back-to-back inputs produce back-to-back outputs in order.
  - Bubbles propagate as valid_out=0.
  - No backpressure.

Test Plan:
- 0x3FC00000 * 0x40000000, RNE, valid_in pulse at cycle N -> valid_out at N+3, out=0x40400000, all flags 0.
- 0x3F800001 * 0x3F800001 -> RNE: out=0x3F800002, inexact=1. Same operands with RUP -> 0x3F800003, inexact=1. RTZ -> 0x3F800002.
- 0x7F000000 * 0x40000000 -> RNE: out=0x7F800000, overflow=1, inexact=1. RTZ: out=0x7F7FFFFF, overflow=1. Sign-flipped operand with RUP: out=0xFF7FFFFF.
- 0x00800000 * 0x3F000000, RNE -> out=0x00000000, underflow=1, inexact=1.
- Upstream bundle with input_is_invalid=1 -> out=0x7FC00000, invalid_operation=1. Bundle with special_case=1, special_result=0x80000000, input_is_flushed=1 -> out=0x80000000, inexact=1.
- Four back-to-back valid ops, then rst=0 asserted one cycle after the last input -> no valid_out for in-flight ops. After release, out=0, flags=0, valid_out=0 until a new op completes 3 cycles later.
